// File: rtl/enc_8b_10b_nlane.sv
// Multi-lane 8b/10b encoder with valid/ready handshake, a running-disparity chain and optional K28.5 idle insertion.
// Defining ENC_8B10B_KERR_CNT_EN adds a saturating kerr_cnt[15:0] output that counts invalid K requests.
module enc_8b_10b_nlane #(
  parameter int LANES       = 2,
  parameter bit IDLE_INSERT = 1'b1,
  parameter bit RD_INIT     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*LANES-1:0]    in_data,
  input  logic [LANES-1:0]      in_k,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [10*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_k_err,
  output logic                  out_idle,
  output logic                  rd_state
`ifdef ENC_8B10B_KERR_CNT_EN
  ,
  output logic [15:0]           kerr_cnt
`endif
);

  // Encodes one byte. Returns {k_err, rd_out, abcdeifghj}.
  // Data tables hold the RD- form; valid K codes are built at RD- and inverted whole at RD+.
  function automatic logic [11:0] enc_byte(input logic [7:0] d, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic [9:0] code;
    logic       valid_k;
    logic       rd_in;
    logic       rd6;
    logic       alt7;
    x = d[4:0];
    y = d[7:5];
    valid_k = k & ((x == 5'd28) |
                   ((y == 3'd7) & ((x == 5'd23) | (x == 5'd27) | (x == 5'd29) | (x == 5'd30))));
    rd_in = rd & ~valid_k;
    case (x)
      5'd0:  s6 = 6'b100111;
      5'd1:  s6 = 6'b011101;
      5'd2:  s6 = 6'b101101;
      5'd3:  s6 = 6'b110001;
      5'd4:  s6 = 6'b110101;
      5'd5:  s6 = 6'b101001;
      5'd6:  s6 = 6'b011001;
      5'd7:  s6 = 6'b111000;
      5'd8:  s6 = 6'b111001;
      5'd9:  s6 = 6'b100101;
      5'd10: s6 = 6'b010101;
      5'd11: s6 = 6'b110100;
      5'd12: s6 = 6'b001101;
      5'd13: s6 = 6'b101100;
      5'd14: s6 = 6'b011100;
      5'd15: s6 = 6'b010111;
      5'd16: s6 = 6'b011011;
      5'd17: s6 = 6'b100011;
      5'd18: s6 = 6'b010011;
      5'd19: s6 = 6'b110010;
      5'd20: s6 = 6'b001011;
      5'd21: s6 = 6'b101010;
      5'd22: s6 = 6'b011010;
      5'd23: s6 = 6'b111010;
      5'd24: s6 = 6'b110011;
      5'd25: s6 = 6'b100110;
      5'd26: s6 = 6'b010110;
      5'd27: s6 = 6'b110110;
      5'd28: s6 = 6'b001110;
      5'd29: s6 = 6'b101110;
      5'd30: s6 = 6'b011110;
      default: s6 = 6'b101011;
    endcase
    if (valid_k && (x == 5'd28)) s6 = 6'b001111;
    // D.07 is balanced but still has an RD+ alternate.
    if (rd_in && (($countones(s6) != 3) || (x == 5'd7))) s6 = ~s6;
    rd6 = rd_in ^ ($countones(s6) != 3);
    alt7 = valid_k | (rd6 ? ((x == 5'd11) | (x == 5'd13) | (x == 5'd14))
                          : ((x == 5'd17) | (x == 5'd18) | (x == 5'd20)));
    case (y)
      3'd0: s4 = 4'b1011;
      3'd1: s4 = 4'b1001;
      3'd2: s4 = 4'b0101;
      3'd3: s4 = 4'b1100;
      3'd4: s4 = 4'b1101;
      3'd5: s4 = 4'b1010;
      3'd6: s4 = 4'b0110;
      default: s4 = alt7 ? 4'b0111 : 4'b1110;
    endcase
    if (rd6 && (($countones(s4) != 2) || (y == 3'd3))) s4 = ~s4;
    code = {s6, s4};
    if (valid_k && rd) code = ~code;
    return {k & ~valid_k, rd ^ ($countones(code) != 5), code};
  endfunction

  logic [8*LANES-1:0]  src_data;
  logic [LANES-1:0]    src_k;
  logic [10*LANES-1:0] enc_data;
  logic [LANES-1:0]    enc_kerr;
  logic                rd_next;
  logic                load;

  assign load     = (~out_valid | out_ready) & ~clr;
  assign in_ready = load;
  // With no input offered the chain encodes K28.5 on every lane for the idle beat.
  assign src_data = in_valid ? in_data : {LANES{8'hBC}};
  assign src_k    = in_valid ? in_k : {LANES{1'b1}};

  always_comb begin
    logic [11:0] res;
    logic        rd_run;
    res      = '0;
    rd_run   = rd_state;
    enc_data = '0;
    enc_kerr = '0;
    for (int i = 0; i < LANES; i++) begin
      res                 = enc_byte(src_data[8*i +: 8], src_k[i], rd_run);
      enc_data[10*i +: 10] = res[9:0];
      enc_kerr[i]         = res[11];
      rd_run              = res[10];
    end
    rd_next = rd_run;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_k_err <= '0;
      out_idle  <= 1'b0;
      rd_state  <= RD_INIT;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_k_err <= '0;
      out_idle  <= 1'b0;
      rd_state  <= RD_INIT;
    end else if (load) begin
      if (in_valid || IDLE_INSERT) begin
        out_valid <= 1'b1;
        out_data  <= enc_data;
        out_k_err <= enc_kerr;
        out_idle  <= ~in_valid;
        rd_state  <= rd_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ENC_8B10B_KERR_CNT_EN
  logic [16:0] kerr_sum;
  assign kerr_sum = {1'b0, kerr_cnt} + 17'($countones(enc_kerr));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      kerr_cnt <= '0;
    end else if (clr) begin
      kerr_cnt <= '0;
    end else if (load && in_valid) begin
      kerr_cnt <= kerr_sum[16] ? 16'hFFFF : kerr_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_enc_8b_10b_nlane.sv
// Directed bench for enc_8b_10b_nlane (LANES=2, IDLE_INSERT=1, RD_INIT=0).
// Beats are compared as {out_valid, out_idle, out_k_err, rd_state, out_data} against hand-encoded values.
module tb_enc_8b_10b_nlane;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_k;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic [1:0]  out_k_err;
  logic        out_idle;
  logic        rd_state;
`ifdef ENC_8B10B_KERR_CNT_EN
  logic [15:0] kerr_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [24:0] obs;
  assign obs = {out_valid, out_idle, out_k_err, rd_state, out_data};

  enc_8b_10b_nlane #(.LANES(2), .IDLE_INSERT(1'b1), .RD_INIT(1'b0)) dut (
    .clk(clk),
    .rst_b(rst_b),
    .clr(clr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_k(in_k),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_k_err(out_k_err),
    .out_idle(out_idle),
    .rd_state(rd_state)
`ifdef ENC_8B10B_KERR_CNT_EN
    ,
    .kerr_cnt(kerr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_k = '0; out_ready = 1'b1;
    step();
    vectors++;
    if (obs !== 25'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %h expected %h", obs, 25'h0);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst_b = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs !== {1'b1, 1'b1, 2'b00, 1'b0, 10'h305, 10'h0FA}) begin
        miscompares++;
        $display("[TB] FAIL idle_beat%0d: got %h expected %h", i, obs,
                 {1'b1, 1'b1, 2'b00, 1'b0, 10'h305, 10'h0FA});
      end
    end
  endtask

  task automatic test_data();
    in_valid = 1'b1; in_k = 2'b00; in_data = 16'h0000;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'b00, 1'b0, 10'h274, 10'h274}) begin
      miscompares++;
      $display("[TB] FAIL data_d0_0: got %h expected %h", obs, {1'b1, 1'b0, 2'b00, 1'b0, 10'h274, 10'h274});
    end
    in_data = 16'hB5F1;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'b00, 1'b1, 10'h2AA, 10'h237}) begin
      miscompares++;
      $display("[TB] FAIL data_d17_7_a7: got %h expected %h", obs, {1'b1, 1'b0, 2'b00, 1'b1, 10'h2AA, 10'h237});
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b1, 2'b00, 1'b1, 10'h0FA, 10'h305}) begin
      miscompares++;
      $display("[TB] FAIL idle_at_rdplus: got %h expected %h", obs, {1'b1, 1'b1, 2'b00, 1'b1, 10'h0FA, 10'h305});
    end
  endtask

  task automatic test_k_codes();
    in_valid = 1'b1; in_k = 2'b01; in_data = 16'h00F7;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'b00, 1'b1, 10'h18B, 10'h057}) begin
      miscompares++;
      $display("[TB] FAIL k23_7_rdplus: got %h expected %h", obs, {1'b1, 1'b0, 2'b00, 1'b1, 10'h18B, 10'h057});
    end
    in_k = 2'b00; in_data = 16'h00EB;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'b00, 1'b0, 10'h274, 10'h348}) begin
      miscompares++;
      $display("[TB] FAIL d11_7_a7_rdplus: got %h expected %h", obs, {1'b1, 1'b0, 2'b00, 1'b0, 10'h274, 10'h348});
    end
    in_k = 2'b10; in_data = 16'hBC00;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'b00, 1'b1, 10'h0FA, 10'h274}) begin
      miscompares++;
      $display("[TB] FAIL k28_5_lane1: got %h expected %h", obs, {1'b1, 1'b0, 2'b00, 1'b1, 10'h0FA, 10'h274});
    end
  endtask

  task automatic test_k_err();
    in_valid = 1'b1; in_k = 2'b01; in_data = 16'h00E1;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'b01, 1'b1, 10'h18B, 10'h22E}) begin
      miscompares++;
      $display("[TB] FAIL kerr_lane0: got %h expected %h", obs, {1'b1, 1'b0, 2'b01, 1'b1, 10'h18B, 10'h22E});
    end
`ifdef ENC_8B10B_KERR_CNT_EN
    vectors++;
    if (kerr_cnt !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL kerr_cnt_one: got %0d expected 1", kerr_cnt);
    end
`endif
    in_k = 2'b11; in_data = 16'hE1E1;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'b11, 1'b1, 10'h22E, 10'h22E}) begin
      miscompares++;
      $display("[TB] FAIL kerr_both: got %h expected %h", obs, {1'b1, 1'b0, 2'b11, 1'b1, 10'h22E, 10'h22E});
    end
`ifdef ENC_8B10B_KERR_CNT_EN
    vectors++;
    if (kerr_cnt !== 16'd3) begin
      miscompares++;
      $display("[TB] FAIL kerr_cnt_three: got %0d expected 3", kerr_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back_stall();
    in_valid = 1'b1; in_k = 2'b00; in_data = 16'hB5F1;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'b00, 1'b0, 10'h2AA, 10'h231}) begin
      miscompares++;
      $display("[TB] FAIL stall_beat_a: got %h expected %h", obs, {1'b1, 1'b0, 2'b00, 1'b0, 10'h2AA, 10'h231});
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_in_ready%0d: got %b expected 0", i, in_ready);
      end
      step();
      vectors++;
      if (obs !== {1'b1, 1'b0, 2'b00, 1'b0, 10'h2AA, 10'h231}) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got %h expected %h", i, obs, {1'b1, 1'b0, 2'b00, 1'b0, 10'h2AA, 10'h231});
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    step();
    vectors++;
    if (obs !== {1'b1, 1'b0, 2'b00, 1'b1, 10'h2AA, 10'h237}) begin
      miscompares++;
      $display("[TB] FAIL stall_beat_b: got %h expected %h", obs, {1'b1, 1'b0, 2'b00, 1'b1, 10'h2AA, 10'h237});
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b1, 2'b00, 1'b1, 10'h0FA, 10'h305}) begin
      miscompares++;
      $display("[TB] FAIL stall_after_idle: got %h expected %h", obs, {1'b1, 1'b1, 2'b00, 1'b1, 10'h0FA, 10'h305});
    end
  endtask

  task automatic test_clr();
    clr = 1'b1; in_valid = 1'b1; in_k = 2'b00; in_data = 16'h0000;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clr_in_ready: got %b expected 0", in_ready);
    end
    step();
    vectors++;
    if ({out_valid, rd_state} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL clr_flush: got valid/rd %b expected 00", {out_valid, rd_state});
    end
`ifdef ENC_8B10B_KERR_CNT_EN
    vectors++;
    if (kerr_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL clr_kerr_cnt: got %0d expected 0", kerr_cnt);
    end
`endif
    clr = 1'b0; in_valid = 1'b0;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b1, 2'b00, 1'b0, 10'h305, 10'h0FA}) begin
      miscompares++;
      $display("[TB] FAIL clr_then_idle: got %h expected %h", obs, {1'b1, 1'b1, 2'b00, 1'b0, 10'h305, 10'h0FA});
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; in_data = 16'hB5F1;
    step();
    rst_b = 1'b0;
    #2;
    vectors++;
    if ({out_valid, rd_state, out_data} !== 22'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %h expected 0", {out_valid, rd_state, out_data});
    end
    in_valid = 1'b0;
    step();
    rst_b = 1'b1;
    step();
    vectors++;
    if (obs !== {1'b1, 1'b1, 2'b00, 1'b0, 10'h305, 10'h0FA}) begin
      miscompares++;
      $display("[TB] FAIL reset_release_idle: got %h expected %h", obs, {1'b1, 1'b1, 2'b00, 1'b0, 10'h305, 10'h0FA});
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_data();
    test_k_codes();
    test_k_err();
    test_back_to_back_stall();
    test_clr();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
